// File: rtl/conv1_pkg.sv
// Shared widths and the FSM state type for the Conv1 row sequencer.
package conv1_pkg;

  localparam int PIX_W = 4;
  localparam int RES_W = 8;
  localparam int TAPS  = 5;
  localparam int IDX_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } conv1_state_t;

endpackage

// File: rtl/conv1_window.sv
// Sliding pixel window feeding Conv1: taps[0] is the oldest pixel, taps[TAPS-1] the newest.
module conv1_window
  import conv1_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          shift,
  input  logic [PIX_W-1:0]              din,
  output logic [TAPS-1:0][PIX_W-1:0]    taps
);

  // New pixels enter at the top so the oldest sample falls off taps[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else if (shift) begin
      taps <= {din, taps[TAPS-1:1]};
    end
  end

endmodule

// File: rtl/conv1_seq.sv
// Row sequencer for Conv1: builds the 5-pixel window, tracks Conv1 latency,
// and tags each result with out_valid and its column index.
module conv1_seq
  import conv1_pkg::*;
#(
  parameter int ROW_LEN  = 28,
  parameter int CONV_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic [PIX_W-1:0] win1,
  output logic [PIX_W-1:0] win2,
  output logic [PIX_W-1:0] win3,
  output logic [PIX_W-1:0] win4,
  output logic [PIX_W-1:0] win5,
  input  logic [RES_W-1:0] conv_out,
  output logic             out_valid,
  output logic [RES_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx
);

  if (ROW_LEN < 5 || ROW_LEN > 1023) begin : g_bad_row_len
    $error("conv1_seq: ROW_LEN must be within 5..1023");
  end
  if (CONV_LAT < 0 || CONV_LAT > 4) begin : g_bad_conv_lat
    $error("conv1_seq: CONV_LAT must be within 0..4");
  end

  localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(TAPS - 2);
  localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(ROW_LEN - 1);

  conv1_state_t                 state, state_nxt;
  logic                         accept;
  logic                         clr;
  logic                         pending;
  logic [IDX_W-1:0]             pix_cnt;
  logic [CONV_LAT:0]            vld;
  logic [TAPS-1:0][PIX_W-1:0]   taps;

  assign accept    = pix_valid && pix_ready;
  assign pix_ready = (state == FILL) || (state == RUN);
  assign busy      = (state != IDLE);
  assign out_valid = vld[CONV_LAT];
  assign out_data  = conv_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          clr       = 1'b1;
        end
      end
      FILL:    if (accept && pix_cnt == FILL_LAST) state_nxt = RUN;
      RUN:     if (accept && pix_cnt == LAST_PIX)  state_nxt = DRAIN;
      DRAIN:   if (!pending)                       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The newest stage is excluded: it is the one presenting out_valid right now.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < CONV_LAT; i++) begin
      pending = pending | vld[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= accept && (state == RUN);
      for (int i = 1; i <= CONV_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      out_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DRAIN) && !pending;
      if (clr) begin
        pix_cnt <= '0;
        out_idx <= '0;
      end else begin
        if (accept)    pix_cnt <= pix_cnt + 1'b1;
        if (out_valid) out_idx <= out_idx + 1'b1;
      end
    end
  end

  conv1_window u_window (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift (accept),
    .din   (pix_data),
    .taps  (taps)
  );

  assign win1 = taps[0];
  assign win2 = taps[1];
  assign win3 = taps[2];
  assign win4 = taps[3];
  assign win5 = taps[4];

endmodule

// File: tb/tb_conv1_seq.sv
// Bench for conv1_seq: an 8-pixel/latency-1 instance and a 5-pixel/latency-0 instance,
// each driven against a behavioural Conv1 model.
module tb_conv1_seq;

  typedef struct {
    logic [3:0]  pix;
    logic [19:0] win;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [9:0] idx;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [3:0] pix_data = '0;
  logic       sel = 1'b0;

  logic       busy_a, done_a, ready_a, ov_a;
  logic [7:0] od_a, conv_a;
  logic [9:0] idx_a;
  logic [3:0] wa [5];
  logic       busy_b, done_b, ready_b, ov_b;
  logic [7:0] od_b, conv_b;
  logic [9:0] idx_b;
  logic [3:0] wb [5];

  logic        m_busy, m_done, m_ready, m_ov;
  logic [7:0]  m_od;
  logic [9:0]  m_idx;
  logic [19:0] m_win;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   last_ov = -10;
  int   done_cnt = 0;
  int   ov_cnt = 0;
  int   lat = 1;
  int   row_len = 8;
  int   start_cyc = 0;
  int   done_cyc = 0;
  exp_t sb [$];
  exp_t e_mon;
  vec_t tbl [8];
  logic [3:0] hist [5];
  int   npix = 0;
  int   nidx = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] conv_f(input logic [3:0] a, b, c, d, e);
    return 8'(a + 2*b + 3*c + 4*d + 5*e);
  endfunction

  // Conv1 stand-ins: one register stage for instance a, purely combinational for b.
  always @(posedge clk) conv_a <= conv_f(wa[0], wa[1], wa[2], wa[3], wa[4]);
  assign conv_b = conv_f(wb[0], wb[1], wb[2], wb[3], wb[4]);

  conv1_seq #(.ROW_LEN(8), .CONV_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .busy(busy_a), .done(done_a),
    .pix_valid(pix_valid && !sel), .pix_ready(ready_a), .pix_data(pix_data),
    .win1(wa[0]), .win2(wa[1]), .win3(wa[2]), .win4(wa[3]), .win5(wa[4]),
    .conv_out(conv_a), .out_valid(ov_a), .out_data(od_a), .out_idx(idx_a)
  );

  conv1_seq #(.ROW_LEN(5), .CONV_LAT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .busy(busy_b), .done(done_b),
    .pix_valid(pix_valid && sel), .pix_ready(ready_b), .pix_data(pix_data),
    .win1(wb[0]), .win2(wb[1]), .win3(wb[2]), .win4(wb[3]), .win5(wb[4]),
    .conv_out(conv_b), .out_valid(ov_b), .out_data(od_b), .out_idx(idx_b)
  );

  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_ov    = sel ? ov_b    : ov_a;
  assign m_od    = sel ? od_b    : od_a;
  assign m_idx   = sel ? idx_b   : idx_a;
  assign m_win   = sel ? {wb[0], wb[1], wb[2], wb[3], wb[4]} : {wa[0], wa[1], wa[2], wa[3], wa[4]};

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic row_reset();
    for (int i = 0; i < 5; i++) hist[i] = '0;
    npix = 0;
    nidx = 0;
  endtask

  task automatic begin_row(input logic hold);
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    row_reset();
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Offer one pixel, wait for acceptance and queue the result it completes.
  task automatic applyStimulus(input logic [3:0] p);
    logic got;
    got = 1'b0;
    pix_data  = p;
    pix_valid = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      got = m_ready;
    end
    checkOutput("pix_accept", got, 1);
    if (got) begin
      for (int i = 0; i < 4; i++) hist[i] = hist[i+1];
      hist[4] = p;
      npix++;
      if (npix >= 5) begin
        sb.push_back('{conv_f(hist[0], hist[1], hist[2], hist[3], hist[4]), 10'(nidx), cyc + lat + 1});
        nidx++;
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    pix_data  = '0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      got = m_done;
    end
    checkOutput("done_seen", got, 1);
    done_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    checkOutput("rst_busy", m_busy, 0);
    checkOutput("rst_done", m_done, 0);
    checkOutput("rst_ready", m_ready, 0);
    checkOutput("rst_out_valid", m_ov, 0);
    checkOutput("rst_out_idx", m_idx, 0);
    checkOutput("rst_window", m_win, 0);
  endtask

  task automatic table_row(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(tbl[i].pix);
      checkOutput("window", m_win, tbl[i].win);
    end
  endtask

  // Scoreboard: every out_valid must match the oldest queued result and arrive on time.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ov) begin
        checkOutput("sb_has_entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          checkOutput("out_data", m_od, e_mon.res);
          checkOutput("out_idx", m_idx, e_mon.idx);
          checkOutput("out_valid_cycle", cyc, e_mon.cyc);
        end
        last_ov = cyc;
        ov_cnt++;
      end
      if (m_done) begin
        checkOutput("done_after_last_ov", cyc, last_ov + 1);
        checkOutput("sb_empty_at_done", sb.size(), 0);
        done_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ov0, d0;
    tbl[0] = '{4'd14, {4'd0,  4'd0,  4'd0,  4'd0,  4'd14}};
    tbl[1] = '{4'd7,  {4'd0,  4'd0,  4'd0,  4'd14, 4'd7 }};
    tbl[2] = '{4'd10, {4'd0,  4'd0,  4'd14, 4'd7,  4'd10}};
    tbl[3] = '{4'd9,  {4'd0,  4'd14, 4'd7,  4'd10, 4'd9 }};
    tbl[4] = '{4'd2,  {4'd14, 4'd7,  4'd10, 4'd9,  4'd2 }};
    tbl[5] = '{4'd4,  {4'd7,  4'd10, 4'd9,  4'd2,  4'd4 }};
    tbl[6] = '{4'd5,  {4'd10, 4'd9,  4'd2,  4'd4,  4'd5 }};
    tbl[7] = '{4'd1,  {4'd9,  4'd2,  4'd4,  4'd5,  4'd1 }};
    row_reset();

    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] nominal row");
    ov0 = ov_cnt;
    begin_row(1'b0);
    table_row(0, 7);
    wait_done();
    checkOutput("nominal_results", ov_cnt - ov0, 4);
    checkOutput("nominal_row_time", done_cyc - start_cyc, row_len + lat + 2);

    $display("[TB] input gap with ignored start");
    ov0 = ov_cnt;
    begin_row(1'b0);
    table_row(0, 4);
    for (int g = 0; g < 3; g++) begin
      if (g == 0) start = 1'b1;
      @(negedge clk);
      checkOutput("gap_window_hold", m_win, tbl[4].win);
      checkOutput("gap_busy", m_busy, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    table_row(5, 7);
    wait_done();
    checkOutput("gap_results", ov_cnt - ov0, 4);

    $display("[TB] back-to-back rows");
    begin_row(1'b1);
    table_row(0, 7);
    wait_done();
    row_reset();
    start = 1'b0;
    checkOutput("b2b_busy", m_busy, 1);
    checkOutput("b2b_ready", m_ready, 1);
    checkOutput("b2b_window_clear", m_win, 0);
    table_row(0, 7);
    wait_done();

    $display("[TB] reset mid-row");
    begin_row(1'b0);
    table_row(0, 5);
    rst = 1'b1;
    sb.delete();
    d0 = done_cnt;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", done_cnt, d0);
    begin_row(1'b0);
    table_row(0, 7);
    wait_done();

    $display("[TB] minimum row, zero latency");
    sel = 1'b1;
    lat = 0;
    row_len = 5;
    ov0 = ov_cnt;
    begin_row(1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(4'(i));
    checkOutput("min_window", m_win, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    wait_done();
    checkOutput("min_results", ov_cnt - ov0, 1);
    checkOutput("min_row_time", done_cyc - start_cyc, row_len + lat + 2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/conv1_seq.md
# conv1_seq

Row sequencer for the Conv1 5-tap convolution stage. Accepts a stream of 4-bit pixels over a valid/ready handshake and builds a 5-pixel sliding window that drives Conv1's `input1`..`input5`. It tracks Conv1's pipeline latency and tags each 8-bit result with `out_valid` and a column index. It runs one row per `start`, emits `ROW_LEN-4` results, then pulses `done`.

## Interface
- `ROW_LEN`, 28: pixels per row; legal range 5..1023, elaboration error outside it.
- `CONV_LAT`, 1: Conv1 clock latency from a window change to `output1` update; legal range 0..4.
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a row; sampled only in IDLE.
- `busy`  out  1  high in FILL, RUN and DRAIN.
- `done`  out  1  one-cycle pulse at end of row.
- `pix_valid`  in  1  pixel present.
- `pix_ready`  out  1  sequencer can accept a pixel.
- `pix_data`  in  4  pixel value, unsigned.
- `win1`..`win5`  out  4 each  window to Conv1 `input1`..`input5`; `win1` is oldest.
- `conv_out`  in  8  Conv1 `output1`.
- `out_valid`  out  1  `out_data` holds a valid window result.
- `out_data`  out  8  `conv_out` passed through combinationally.
- `out_idx`  out  10  column of the result, 0..`ROW_LEN-5`.

## Operation
- Accept means `pix_valid && pix_ready` at a rising edge.
- Shift on accept: `win5<=pix_data`, `win4<=win5`, `win3<=win4`, `win2<=win3`, `win1<=win2`. Without an accept, the window holds.
- States:
  - IDLE: `pix_ready=0`. On `start`, clear the window and counters, then go to FILL.
  - FILL: `pix_ready=1`. Go to RUN on the 4th accept.
  - RUN: `pix_ready=1`. Each accept makes a window. The accept of pixel `ROW_LEN-1` goes to DRAIN.
  - DRAIN: `pix_ready=0`. Wait until the latency pipe is empty, then go to IDLE and assert `done` in that first IDLE cycle.
- Latency pipe `vld[0..CONV_LAT]`: `vld[0]<=` accept-in-RUN, `vld[i]<=vld[i-1]`, `out_valid=vld[CONV_LAT]`.
- `out_idx` starts at 0 on `start` and increments after each `out_valid` cycle.
- `start` is ignored while `busy`.
- `start` in the `done` cycle is legal: the next row begins with no idle gap.
- Gaps in `pix_valid` insert bubbles in `out_valid`. Result order is preserved.
- There is no downstream backpressure. The consumer must take every `out_valid` cycle.
- `rst` mid-row clears everything to reset values. The pipe is flushed, no `done` is generated and no further `out_valid` appears.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pix_ready`, `out_valid` = 0; `win1`..`win5` = 0; `out_idx` = 0; pixel counter and pipe = 0.
- `pix_ready` and `busy` are registered from state.
- `out_valid` rises CONV_LAT+1 cycles after the acceptance cycle of the window's newest pixel. With CONV_LAT=1 that is 2 cycles.
- `done` comes exactly 1 cycle after the last `out_valid`.
- Minimum row time with no stalls: 1 (start) + ROW_LEN + CONV_LAT + 1 cycles to `done`.
- Pixel counter is 10 bits. It does not wrap within a row because RUN ends at `ROW_LEN-1`.

## Structure
- Package `conv1_pkg`:
  - `PIX_W=4`, `RES_W=8`, `TAPS=5`, `IDX_W=10`.
  - State enum `conv1_state_t` {IDLE, FILL, RUN, DRAIN}.
- Sub-module `conv1_window`: 5-deep `PIX_W` shift register with `clr` and `shift` inputs, exposing all taps.
- The top level holds the FSM, counters and latency pipe, and instantiates `conv1_window`. Conv1 itself stays outside, wired by the parent.

## Test plan
- Nominal row: ROW_LEN=8, CONV_LAT=1, no stalls, pixels 14,7,10,9,2,4,5,1.
  - Windows seen are (14,7,10,9,2), (7,10,9,2,4), (10,9,2,4,5), (9,2,4,5,1).
  - 4 `out_valid` pulses, `out_idx` 0..3, each 2 cycles after its accept; `done` 1 cycle after the last pulse.
- Input gaps: same pixels with `pix_valid` low for 3 cycles after pixel 5.
  - Window holds during the gap; `out_valid` gets a 3-cycle gap.
  - `out_data` sequence and `out_idx` values are unchanged.
- Back-to-back rows: `start` held high through `done`.
  - The second row enters FILL in the `done` cycle.
  - Window is cleared to 0 before its first pixel; `out_idx` restarts at 0.
- Reset mid-row: assert `rst` for 1 cycle after pixel 6 of the nominal row.
  - All outputs go to reset values immediately.
  - No `out_valid` or `done` follows; a new `start` runs a clean row.
- Ignored start and minimum row: `start` pulsed during RUN has no effect.
  - ROW_LEN=5 gives exactly one result (`out_idx`=0) for pixels 1,2,3,4,5.
  - CONV_LAT=0 gives `out_valid` 1 cycle after the 5th accept.
